nibble_serial_adder_ctrl: RTL
=============================

Name: nibble_serial_adder_ctrl

Overview:
- Sequences one shared 4-bit ripple-carry adder slice to add two WIDTH-bit operands, one nibble per clock, LSB nibble first.
- A registered carry links consecutive nibbles.
- Valid/ready handshake on input and output; one operation in flight at a time.
- Used where a wide adder is too costly and multi-cycle latency is acceptable.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise).
- NIB (derived, localparam), WIDTH/4, number of nibble steps.
- CNT_W (derived, localparam), max(1, clog2(NIB)), nibble counter width.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A, sampled on accept.
- b  input  WIDTH  operand B, sampled on accept.
- cin  input  1  carry-in, sampled on accept.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  result, a+b+cin mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0.
  - Operand shift registers, carry register and counter all cleared.
  - Applies immediately, including mid-RUN or mid-DONE. A partial result is discarded and never presented.
- FSM states are IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch a->a_sh, b->b_sh, cin->carry_r; cnt=0; go to RUN.
  - in_valid without acceptance has no effect.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle the slice adds a_sh[3:0], b_sh[3:0], carry_r.
  - At the edge:
    - The nibble result enters sum_sh from the MSB end: sum_sh = {nib, sum_sh[WIDTH-1:4]}.
    - carry_r = slice carry-out.
    - a_sh and b_sh shift right by 4.
    - cnt increments.
  - When cnt==NIB-1 at an edge, go to DONE.
  - RUN lasts exactly NIB cycles.
- DONE:
  - out_valid=1, sum=sum_sh, cout=carry_r. All three are registered and held stable while out_ready=0.
  - On out_ready=1 at an edge: go to IDLE, out_valid drops.
  - in_ready=0 in DONE; no bypass into the next operation.
- Latency: accept edge T gives out_valid high after edge T+NIB. Minimum initiation interval is NIB+2 cycles.
- in_valid during RUN/DONE: ignored; the requester must hold it until in_ready.
- The carry ripples through all nibbles with no early termination, so the cycle count is independent of data.
- sum and cout are don't-care-stable outside DONE: they hold the last result (0 after reset).
- No X propagation: all registers have reset values.

Decomposition:
- Shared package adder_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - NIBBLE_W=4 constant;
  - width-check function.
- Sub-module nibble_rca4: combinational 4-bit ripple-carry slice (a[3:0], b[3:0], ci -> s[3:0], co), built from gate-level full adders. It is instantiated once in the controller.

Test Plan:
1. WIDTH=16: a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0. out_valid rises exactly 4 cycles after the accept edge.
2. WIDTH=16: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry crosses all nibbles). Also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
3. Backpressure: hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 and new operands. Required response:
   - sum and cout stay stable, in_ready stays 0;
   - the new operands are accepted only after out_ready and the return to IDLE;
   - the second result is correct.
4. Reset mid-RUN: drop rst_n after 2 nibble steps -> out_valid=0, sum=0, cout=0 and in_ready=1 immediately. After release, a fresh 0x00FF+0x0001 gives 0x0100, cout=0.
5. WIDTH=4 instance: a=0x9, b=0x8, cin=0 -> sum=0x1, cout=1, latency 1 cycle. Also a=0x7, b=0x8, cin=1 -> sum=0x0, cout=1.
6. Randomised back-to-back stream (200 ops, out_ready toggling randomly) against a reference a+b+cin model. All results match in order, with no drops or duplicates.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   NIBBLE_W  : width of the shared adder slice
//   state_e   : controller states
//   width_ok  : legal operand widths are positive multiples of NIBBLE_W
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic bit width_ok(input int w);
    return (w >= NIBBLE_W) && ((w % NIBBLE_W) == 0);
  endfunction

endpackage

// File: rtl/nibble_rca4.sv
// Combinational 4-bit ripple-carry adder slice built from gate-level full adders.
// Ports:
//   a, b [3:0] : addend nibbles
//   ci         : carry in
//   s [3:0]    : sum nibble
//   co         : carry out of bit 3
module nibble_rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    logic w_p;
    assign w_p        = a[i] ^ b[i];
    assign s[i]       = w_p ^ w_c[i];
    assign w_c[i + 1] = (a[i] & b[i]) | (w_p & w_c[i]);
  end

  assign co = w_c[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder: one shared 4-bit slice adds two WIDTH-bit operands over
// WIDTH/4 cycles, LSB nibble first, with a registered carry between nibbles.
// Ports:
//   clk, rst_n             : clock, async active-low reset
//   in_valid/in_ready      : operand handshake (a, b, cin sampled on accept)
//   out_valid/out_ready    : result handshake
//   sum [WIDTH-1:0], cout  : a+b+cin, held until the next result
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one nibble added per cycle, exactly NIB cycles
// DONE  | result presented, waiting for out_ready
module nibble_serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  state_e           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic [NIBBLE_W-1:0] w_nib;
  logic                w_co;
  logic [WIDTH-1:0]    w_sum_full;

  nibble_rca4 u_rca (
    .a  (r_a_sh[NIBBLE_W-1:0]),
    .b  (r_b_sh[NIBBLE_W-1:0]),
    .ci (r_carry),
    .s  (w_nib),
    .co (w_co)
  );

  // Partial sum: earlier nibbles sit in the top of r_part and slide down as
  // new ones arrive, so after the last step {w_nib, r_part} is the full sum.
  // A single-nibble adder needs no partial storage.
  if (NIB > 1) begin : g_part
    logic [WIDTH-NIBBLE_W-1:0] r_part;

    assign w_sum_full = {w_nib, r_part};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_part <= '0;
      end else if (r_state == RUN) begin
        r_part <= w_sum_full[WIDTH-1:NIBBLE_W];
      end
    end
  end else begin : g_no_part
    assign w_sum_full = w_nib;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_carry  <= cin;
            r_cnt    <= '0;
            in_ready <= 1'b0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_a_sh  <= r_a_sh >> NIBBLE_W;
          r_b_sh  <= r_b_sh >> NIBBLE_W;
          r_carry <= w_co;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(NIB - 1)) begin
            // Load the outputs on the same edge as the last nibble so the
            // result is valid the cycle DONE is entered.
            sum       <= w_sum_full;
            cout      <= w_co;
            out_valid <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule
